// File: rtl/piso_serializer.sv
// ---------------------------------------------------------------------------
// piso_serializer
//
// Parallel-in, serial-out word serializer. Words arrive over a valid/ready
// handshake into a one-entry hold buffer. From there they move into a shift
// register and leave one bit per shift_en strobe. The bit at the emitting end
// goes out first: bit 0 when LSB_FIRST = 1, bit WIDTH-1 when LSB_FIRST = 0.
// A buffered word is loaded on the same edge that consumes the last bit of
// the current word. Back-to-back words therefore form one continuous stream,
// with sout_valid held high across the word boundary.
//
// Parameters:
//   WIDTH      word width in bits (>= 2)
//   LSB_FIRST  1: bit 0 leaves first, 0: bit WIDTH-1 leaves first
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous reset, active-high
//   shift_en    bit-rate strobe; a serial bit is consumed only when 1
//   din         parallel word, sampled on a handshake
//   din_valid   upstream word valid
//   din_ready   hold buffer is empty and can take a word
//   sout        current serial bit (0 outside a frame)
//   sout_valid  sout carries a frame bit
//   frame_last  sout is the final bit of the current word
//   busy        a word is buffered or being shifted
// ---------------------------------------------------------------------------
module piso_serializer #(
    parameter int WIDTH     = 4,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             shift_en,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             frame_last,
    output logic             busy
);

    localparam int                CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Registered state
    state_t           state;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] hb;
    logic             hb_full;
    logic [CNT_W-1:0] cnt;

    // Next-state values
    state_t           nxt_state;
    logic [WIDTH-1:0] nxt_sr;
    logic [WIDTH-1:0] nxt_hb;
    logic             nxt_hb_full;
    logic [CNT_W-1:0] nxt_cnt;
    logic             nxt_emit;

    logic             accept;
    logic             drain;
    logic [WIDTH-1:0] sr_shifted;

    // The handshake depends only on registered buffer state. This keeps
    // din_ready free of any combinational path from din_valid or shift_en.
    assign din_ready = !hb_full;
    assign accept    = din_valid && !hb_full;

    // Move the word one position toward the emitting end.
    assign sr_shifted = LSB_FIRST ? {1'b0, sr[WIDTH-1:1]} : {sr[WIDTH-2:0], 1'b0};

    // NOTE: every signal driven here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        nxt_state   = state;
        nxt_sr      = sr;
        nxt_cnt     = cnt;
        nxt_hb      = hb;
        nxt_hb_full = hb_full;
        drain       = 1'b0;

        unique case (state)
            IDLE: begin
                if (hb_full) begin
                    nxt_state = SHIFT;
                    nxt_sr    = hb;
                    nxt_cnt   = '0;
                    drain     = 1'b1;
                end
            end
            SHIFT: begin
                if (shift_en) begin
                    if (cnt == LAST_CNT) begin
                        // The buffered word follows on the very next bit
                        // slot, with no idle cycle between the two words.
                        if (hb_full) begin
                            nxt_sr  = hb;
                            nxt_cnt = '0;
                            drain   = 1'b1;
                        end else begin
                            nxt_state = IDLE;
                        end
                    end else begin
                        nxt_sr  = sr_shifted;
                        nxt_cnt = cnt + CNT_W'(1);
                    end
                end
            end
            default: nxt_state = IDLE;
        endcase

        // A handshake wins over a drain on the same edge: the buffer ends
        // up full again, now holding the new word.
        if (drain) begin
            nxt_hb_full = 1'b0;
        end
        if (accept) begin
            nxt_hb      = din;
            nxt_hb_full = 1'b1;
        end
    end

    assign nxt_emit = LSB_FIRST ? nxt_sr[0] : nxt_sr[WIDTH-1];

    // Outputs are registered from the next-state values. They therefore
    // always describe the state register's current contents, and an
    // asynchronous reset clears them at once.
    // NOTE: sequential state is updated only with non-blocking assignments,
    // so every register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            sr         <= '0;
            hb         <= '0;
            hb_full    <= 1'b0;
            cnt        <= '0;
            sout       <= 1'b0;
            sout_valid <= 1'b0;
            frame_last <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= nxt_state;
            sr         <= nxt_sr;
            hb         <= nxt_hb;
            hb_full    <= nxt_hb_full;
            cnt        <= nxt_cnt;
            sout       <= (nxt_state == SHIFT) && nxt_emit;
            sout_valid <= (nxt_state == SHIFT);
            frame_last <= (nxt_state == SHIFT) && (nxt_cnt == LAST_CNT);
            busy       <= (nxt_state == SHIFT) || nxt_hb_full;
        end
    end

endmodule
